// File: rtl/mcpu_run_monitor.sv
// Run controller beside MultiCycleCPU: holds the CPU in reset for a programmable time, runs it
// under a watchdog, counts cycles and instructions, and keeps a circular trace of data changes.
module mcpu_run_monitor #(
  parameter int                 DATA_W       = 32,
  parameter int                 STATE_W      = 8,
  parameter logic [STATE_W-1:0] FETCH_STATE  = 8'h00,
  parameter logic [STATE_W-1:0] HALT_STATE   = 8'hFF,
  parameter int                 RESET_CYCLES = 2,
  parameter int                 MAX_CYCLES   = 50,
  parameter int                 TRACE_DEPTH  = 8,
  parameter int                 CNT_W        = 16,
  localparam int                TRACE_AW     = $clog2(TRACE_DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [STATE_W-1:0]  i_state,
  input  logic [DATA_W-1:0]   i_data_out,
  input  logic [TRACE_AW-1:0] i_rd_idx,
  output logic                o_cpu_rst_n,
  output logic                o_running,
  output logic                o_done,
  output logic                o_timeout,
  output logic [CNT_W-1:0]    o_cycle_cnt,
  output logic [CNT_W-1:0]    o_instr_cnt,
  output logic [TRACE_AW:0]   o_trace_cnt,
  output logic [DATA_W-1:0]   o_rd_data
);

  // state   | meaning
  // IDLE    | CPU in reset, waiting for i_start
  // HOLD    | CPU in reset, hold timer counting down
  // RUN     | CPU released, counting and tracing
  // DONE    | halt seen, CPU back in reset, results frozen
  // TIMEOUT | watchdog expired, CPU back in reset, results frozen
  typedef enum logic [2:0] {IDLE, HOLD, RUN, DONE, TIMEOUT} state_e;

  localparam int HOLD_W = $clog2(RESET_CYCLES) + 1;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    instr_q, instr_d;
  logic [TRACE_AW:0]   tcnt_q, tcnt_d;
  logic [TRACE_AW-1:0] wptr_q, wptr_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic [STATE_W-1:0]  prev_q, prev_d;
  logic                first_q, first_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                wr_en;
  logic [TRACE_AW-1:0] oldest;
  logic [DATA_W-1:0]   mem_q [TRACE_DEPTH];

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cycle_d   = cycle_q;
    instr_d   = instr_q;
    tcnt_d    = tcnt_q;
    wptr_d    = wptr_q;
    last_d    = last_q;
    prev_d    = prev_q;
    first_d   = first_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    wr_en     = 1'b0;
    case (state_q)
      IDLE, DONE, TIMEOUT: begin
        if (i_start) begin
          state_d   = HOLD;
          hold_d    = HOLD_W'(RESET_CYCLES - 1);
          cycle_d   = '0;
          instr_d   = '0;
          tcnt_d    = '0;
          wptr_d    = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      HOLD: begin
        if (hold_q == '0) begin
          state_d = RUN;
          first_d = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      RUN: begin
        first_d = 1'b0;
        prev_d  = i_state;
        cycle_d = cycle_q + 1'b1;
        if (i_state == FETCH_STATE && (first_q || i_state != prev_q))
          instr_d = instr_q + 1'b1;
        if (first_q || i_data_out != last_q) begin
          wr_en  = 1'b1;
          last_d = i_data_out;
          wptr_d = wptr_q + 1'b1;
          if (tcnt_q != (TRACE_AW+1)'(TRACE_DEPTH))
            tcnt_d = tcnt_q + 1'b1;
        end
        // Halt takes priority over a watchdog expiring on the same edge.
        if (i_state == HALT_STATE) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (cycle_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d   = TIMEOUT;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    cpu_rst_n_d = (state_d == RUN);
  end

  // Until the buffer has wrapped the oldest entry sits at slot 0; afterwards it is at wptr.
  always_comb begin
    oldest    = (tcnt_q == (TRACE_AW+1)'(TRACE_DEPTH)) ? wptr_q : '0;
    rd_data_d = '0;
    if ({1'b0, i_rd_idx} < tcnt_q)
      rd_data_d = mem_q[oldest + i_rd_idx];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      cycle_q     <= '0;
      instr_q     <= '0;
      tcnt_q      <= '0;
      wptr_q      <= '0;
      last_q      <= '0;
      prev_q      <= '0;
      first_q     <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
      tcnt_q      <= tcnt_d;
      wptr_q      <= wptr_d;
      last_q      <= last_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Entries past o_trace_cnt are masked on read, so the storage itself needs no reset.
  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem_q[wptr_q] <= i_data_out;
  end

  assign o_cpu_rst_n = cpu_rst_n_q;
  assign o_running   = (state_q == RUN);
  assign o_done      = done_q;
  assign o_timeout   = timeout_q;
  assign o_cycle_cnt = cycle_q;
  assign o_instr_cnt = instr_q;
  assign o_trace_cnt = tcnt_q;
  assign o_rd_data   = rd_data_q;

endmodule

// File: tb/tb_mcpu_run_monitor.sv
// Bench for mcpu_run_monitor: directed and randomized CPU runs compared against a
// sequence-level model of cycle/instruction counts and the trace contents.
module tb_mcpu_run_monitor;

  localparam int MAX   = 50;
  localparam int DEPTH = 8;
  localparam logic [7:0] FETCH = 8'h00;
  localparam logic [7:0] HALT  = 8'hFF;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [7:0]  i_state;
  logic [31:0] i_data_out;
  logic [2:0]  i_rd_idx;
  logic        o_cpu_rst_n, o_running, o_done, o_timeout;
  logic [15:0] o_cycle_cnt, o_instr_cnt;
  logic [3:0]  o_trace_cnt;
  logic [31:0] o_rd_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  st [MAX];
  logic [31:0] dt [MAX];
  bit          exp_halt;
  int          exp_cycles;
  int          exp_instr;
  logic [31:0] exp_q [$];

  mcpu_run_monitor dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_state(i_state),
    .i_data_out(i_data_out), .i_rd_idx(i_rd_idx), .o_cpu_rst_n(o_cpu_rst_n),
    .o_running(o_running), .o_done(o_done), .o_timeout(o_timeout),
    .o_cycle_cnt(o_cycle_cnt), .o_instr_cnt(o_instr_cnt),
    .o_trace_cnt(o_trace_cnt), .o_rd_data(o_rd_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Whole-run view: the run ends at the first halt or after MAX cycles; an instruction is a
  // fetch that starts a new fetch stretch; the trace keeps the last DEPTH distinct-from-previous values.
  function automatic void compute_model();
    logic [7:0]  prev_s;
    logic [31:0] last_d;
    exp_halt   = 1'b0;
    exp_cycles = MAX;
    for (int i = 0; i < MAX; i++)
      if (st[i] == HALT) begin exp_halt = 1'b1; exp_cycles = i + 1; break; end
    exp_instr = 0;
    exp_q.delete();
    prev_s = 8'h00;
    last_d = 32'h0;
    for (int i = 0; i < exp_cycles; i++) begin
      if (st[i] == FETCH && (i == 0 || st[i] != prev_s)) exp_instr++;
      prev_s = st[i];
      if (i == 0 || dt[i] != last_d) begin
        exp_q.push_back(dt[i]);
        last_d = dt[i];
        if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      end
    end
  endfunction

  task automatic do_start();
    i_start = 1'b1; tick();
    i_start = 1'b0; tick(); tick();
  endtask

  task automatic drive_program();
    compute_model();
    do_start();
    for (int k = 0; k < exp_cycles; k++) begin
      i_state = st[k]; i_data_out = dt[k]; tick();
    end
    i_state = 8'h01;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_state = 8'h01; i_data_out = '0; i_rd_idx = '0;
    #2;
    checks++;
    if ({o_cpu_rst_n, o_running, o_done, o_timeout} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {o_cpu_rst_n, o_running, o_done, o_timeout});
    end
    checks++;
    if ({o_cycle_cnt, o_instr_cnt, o_trace_cnt, o_rd_data} !== '0) begin
      errors++; $display("FAIL reset_counts got %h/%h/%h/%h want 0", o_cycle_cnt, o_instr_cnt, o_trace_cnt, o_rd_data);
    end
    #5 i_rst = 1'b0;
    tick();
  endtask

  task automatic test_release();
    i_start = 1'b1; tick();
    i_start = 1'b0;
    checks++;
    if (o_cpu_rst_n !== 1'b0) begin errors++; $display("FAIL release_e0 got %b want 0", o_cpu_rst_n); end
    tick();
    checks++;
    if (o_cpu_rst_n !== 1'b0) begin errors++; $display("FAIL release_e1 got %b want 0", o_cpu_rst_n); end
    tick();
    checks++;
    if ({o_cpu_rst_n, o_running} !== 2'b11) begin
      errors++; $display("FAIL release_e2 got %b want 11", {o_cpu_rst_n, o_running});
    end
    i_state = HALT; tick(); i_state = 8'h01;
  endtask

  task automatic test_halt();
    for (int i = 0; i < MAX; i++) begin st[i] = 8'h01; dt[i] = 32'(i); end
    st[0] = 8'h00; st[1] = 8'h01; st[2] = 8'h02; st[3] = 8'h00; st[4] = 8'h01; st[5] = 8'hFF;
    drive_program();
    checks++;
    if (o_instr_cnt !== 16'd2) begin errors++; $display("FAIL halt_instr got %0d want 2", o_instr_cnt); end
    checks++;
    if (o_cycle_cnt !== 16'd6) begin errors++; $display("FAIL halt_cycles got %0d want 6", o_cycle_cnt); end
    checks++;
    if ({o_done, o_timeout, o_cpu_rst_n, o_running} !== 4'b1000) begin
      errors++; $display("FAIL halt_flags got %b want 1000", {o_done, o_timeout, o_cpu_rst_n, o_running});
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < MAX; i++) begin st[i] = 8'h01; dt[i] = 32'h55; end
    drive_program();
    checks++;
    if ({o_timeout, o_done} !== 2'b10) begin errors++; $display("FAIL timeout_flags got %b want 10", {o_timeout, o_done}); end
    checks++;
    if (o_cycle_cnt !== 16'(MAX)) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", o_cycle_cnt, MAX); end
    checks++;
    if (o_trace_cnt !== 4'd1) begin errors++; $display("FAIL timeout_trace got %0d want 1", o_trace_cnt); end
    tick(); tick();
    checks++;
    if (o_cycle_cnt !== 16'(MAX)) begin errors++; $display("FAIL timeout_frozen got %0d want %0d", o_cycle_cnt, MAX); end
  endtask

  task automatic test_trace();
    for (int i = 0; i < MAX; i++) begin st[i] = 8'h02; dt[i] = (i < 10) ? 32'(i + 1) : 32'd10; end
    st[12] = HALT;
    drive_program();
    checks++;
    if (o_trace_cnt !== 4'd8) begin errors++; $display("FAIL trace_cnt got %0d want 8", o_trace_cnt); end
    i_rd_idx = 3'd0; tick();
    checks++;
    if (o_rd_data !== 32'd3) begin errors++; $display("FAIL trace_idx0 got %0d want 3", o_rd_data); end
    i_rd_idx = 3'd7; #1;
    checks++;
    if (o_rd_data !== 32'd3) begin errors++; $display("FAIL trace_lag got %0d want 3", o_rd_data); end
    tick();
    checks++;
    if (o_rd_data !== 32'd10) begin errors++; $display("FAIL trace_idx7 got %0d want 10", o_rd_data); end
  endtask

  task automatic test_halt_at_limit();
    for (int i = 0; i < MAX; i++) begin st[i] = 8'h00; dt[i] = 32'h7; end
    st[MAX-1] = HALT;
    drive_program();
    checks++;
    if ({o_done, o_timeout} !== 2'b10) begin errors++; $display("FAIL limit_flags got %b want 10", {o_done, o_timeout}); end
    checks++;
    if (o_cycle_cnt !== 16'(MAX)) begin errors++; $display("FAIL limit_cycles got %0d want %0d", o_cycle_cnt, MAX); end
    checks++;
    if (o_instr_cnt !== 16'd1) begin errors++; $display("FAIL limit_instr got %0d want 1", o_instr_cnt); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < MAX; i++) begin
        st[i] = 8'($urandom_range(0, 3));
        dt[i] = 32'($urandom_range(0, 3)) * 32'h1111;
      end
      if (r % 4 != 3) st[$urandom_range(2, MAX - 1)] = HALT;
      drive_program();
      checks++;
      if (o_cycle_cnt !== 16'(exp_cycles)) begin
        errors++; $display("FAIL rand%0d_cycles got %0d want %0d", r, o_cycle_cnt, exp_cycles);
      end
      checks++;
      if (o_instr_cnt !== 16'(exp_instr)) begin
        errors++; $display("FAIL rand%0d_instr got %0d want %0d", r, o_instr_cnt, exp_instr);
      end
      checks++;
      if ({o_done, o_timeout} !== {exp_halt, !exp_halt}) begin
        errors++; $display("FAIL rand%0d_flags got %b want %b", r, {o_done, o_timeout}, {exp_halt, !exp_halt});
      end
      checks++;
      if (o_trace_cnt !== 4'(exp_q.size())) begin
        errors++; $display("FAIL rand%0d_tcnt got %0d want %0d", r, o_trace_cnt, exp_q.size());
      end
      for (int idx = 0; idx < DEPTH; idx++) begin
        logic [31:0] want;
        want = (idx < exp_q.size()) ? exp_q[idx] : 32'h0;
        i_rd_idx = 3'(idx); tick();
        checks++;
        if (o_rd_data !== want) begin
          errors++; $display("FAIL rand%0d_rd%0d got %h want %h", r, idx, o_rd_data, want);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_start();
    for (int k = 0; k < 3; k++) begin i_state = FETCH; i_data_out = 32'(k + 9); tick(); end
    i_rd_idx = 3'd0; tick();
    checks++;
    if (o_running !== 1'b1) begin errors++; $display("FAIL arst_pre running got %b want 1", o_running); end
    #3 i_rst = 1'b1;
    #1;
    checks++;
    if ({o_cpu_rst_n, o_running, o_done, o_timeout} !== 4'b0) begin
      errors++; $display("FAIL arst_flags got %b want 0000", {o_cpu_rst_n, o_running, o_done, o_timeout});
    end
    checks++;
    if ({o_cycle_cnt, o_instr_cnt, o_trace_cnt, o_rd_data} !== '0) begin
      errors++; $display("FAIL arst_counts got %h/%h/%h/%h want 0", o_cycle_cnt, o_instr_cnt, o_trace_cnt, o_rd_data);
    end
    i_rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_release();
    test_halt();
    test_timeout();
    test_trace();
    test_halt_at_limit();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
